dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the pipeline's MEM stage. It accepts one load or store request
//  at a time over a valid/ready handshake, models LATENCY wait states, and returns read data
//  or a store acknowledge over a valid/ready response channel.
//  Busy lets the MEM/WB pipeline registers hold while an access is outstanding.
// PARAMETERS
//  DEPTH    256  number of 32-bit words; power of 2, >= 4
//  LATENCY  2    wait cycles between acceptance and response; 1..15
// PORTS
//  Clk        in   1   single clock; all state updates on posedge Clk
//  Rst_n      in   1   asynchronous, active-low reset
//  ReqValid   in   1   request present (MEM stage MemRead or MemWrite)
//  ReqReady   out  1   responder can accept a request this cycle
//  ReqWrite   in   1   1 = store, 0 = load
//  ReqAddr    in   32  byte address (ALU result)
//  ReqWData   in   32  store data (forwarded rt value)
//  ReqByteEn  in   4   store byte enables; bit i writes bits [8i+7:8i]; ignored on loads
//  RespValid  out  1   response present
//  RespReady  in   1   pipeline accepts the response
//  RespRData  out  32  load data; 0 for stores and errors
//  RespErr    out  1   misaligned or out-of-range access
//  Busy       out  1   request accepted and not yet completed (state != IDLE)
// BEHAVIOUR
//  - Reset (Rst_n=0, asynchronous): state=IDLE, ReqReady=1, RespValid=0, RespRData=0,
//    RespErr=0, Busy=0, wait counter=0. Memory contents are not reset.
//  - Handshake: a transfer occurs when Valid&&Ready are both high at a posedge.
//    Request fields are sampled only at the accept edge. Response outputs stay stable while
//    RespValid=1 && RespReady=0.
//  - FSM IDLE -> WAIT -> RESP -> IDLE:
//    - IDLE: ReqReady=1. On accept, latch addr/wdata/byteen/write and load cnt=LATENCY-1.
//      Go to WAIT.
//    - WAIT: ReqReady=0. cnt decrements each cycle. At the edge where cnt==0, perform the
//      access and go to RESP:
//      - store commits to the array on that edge;
//      - load registers the array word into RespRData.
//    - RESP: RespValid=1. ReqReady=RespReady, so a back-to-back request may be accepted on
//      the same edge the response retires.
//      - RespReady=1 with new accept: go to WAIT with the new request latched.
//      - RespReady=1 without new accept: go to IDLE.
//      - RespReady=0: stay in RESP.
//  - Latency: request accepted at edge N gives RespValid=1 after edge N+LATENCY.
//    Minimum request-to-request spacing is LATENCY+1 cycles.
//  - Index: word index = addr[ADDR_W+1:2], with ADDR_W=$clog2(DEPTH).
//  - Error: addr[1:0]!=0, or addr[31:ADDR_W+2]!=0. On error:
//    - the access is suppressed (no write, RespRData=0);
//    - RespErr=1 with RespValid;
//    - timing is otherwise identical.
//  - Byte enables: a store with ReqByteEn=0 completes normally and leaves memory unchanged.
//    Loads always return the full word.
//  - RespErr and RespRData are cleared when the response retires to IDLE.
//  - Reset mid-operation: any uncommitted store is discarded; a store committed at an earlier
//    edge is kept. No response is produced for the aborted request.
//  - ReqValid while not ready is ignored. The requester must hold its fields until accepted.
// STRUCTURE
//  - Shared package mips_pkg holds:
//    - dmem_state_t enum {IDLE=2'd0, WAIT=2'd1, RESP=2'd2};
//    - DMEM_DEPTH_DEF=256 and DMEM_LAT_DEF=2;
//    - the constant widths WORD_W=32 and BE_W=4.
//  - Sub-module dmem_array: single-port synchronous RAM, DEPTH x 32, byte-enabled write,
//    registered read with one-cycle read. It has no reset.
//  - The FSM, counter, error check and handshake stay in this module.
// TESTING
//  1. Store then load: store ReqAddr=0x10, WData=0xDEADBEEF, ByteEn=4'hF, LATENCY=2;
//     then load 0x10 -> RespValid 2 cycles after each accept, RespRData=0xDEADBEEF, RespErr=0.
//  2. Partial store: 0x12345678 at 0x20, then ByteEn=4'b0010 with WData=0x0000AB00;
//     load 0x20 -> 0x1234AB78.
//  3. Backpressure and back-to-back: hold RespReady=0 for 3 cycles -> RespValid and
//     RespRData stable, ReqReady=0. Then RespReady=1 with a new ReqValid on the same edge
//     -> new request accepted, Busy stays 1.
//  4. Errors: load 0x13 -> RespErr=1, RespRData=0. Store to 0x400 (DEPTH=256) -> RespErr=1,
//     and a subsequent load of 0x0 shows word 0 unchanged.
//  5. Reset mid-operation: drop Rst_n while in WAIT on a store to 0x30 (old value
//     0x11111111) -> outputs immediately 0, ReqReady=1; load 0x30 returns 0x11111111.
//  6. Latency sweep: LATENCY=1 and 15 -> accept-to-RespValid equals LATENCY; cycle count
//     checked by the scoreboard.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: data-memory responder state encoding, defaults and widths.
package mips_pkg;

  localparam int WORD_W         = 32;
  localparam int BE_W           = 4;
  localparam int DMEM_DEPTH_DEF = 256;
  localparam int DMEM_LAT_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM, byte-enabled write, registered one-cycle read.
// Contents are deliberately not reset.
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              En,
  input  logic              We,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [BE_W-1:0]   ByteEn,
  input  logic [WORD_W-1:0] WData,
  output logic [WORD_W-1:0] RData
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (En) begin
      if (We) begin
        for (int i = 0; i < BE_W; i++) begin
          if (ByteEn[i]) mem[Addr][8*i +: 8] <= WData[8*i +: 8];
        end
      end else begin
        RData <= mem[Addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one outstanding load/store, LATENCY wait states,
// valid/ready request and response channels.
//
//  state | meaning
//  IDLE  | ready for a request, no response pending
//  WAIT  | request latched, counting down; access happens on the cnt==0 edge
//  RESP  | response presented, held until RespReady
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH_DEF,
  parameter int LATENCY = DMEM_LAT_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [WORD_W-1:0] ReqAddr,
  input  logic [WORD_W-1:0] ReqWData,
  input  logic [BE_W-1:0]   ReqByteEn,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [WORD_W-1:0] RespRData,
  output logic              RespErr,
  output logic              Busy
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  dmem_state_t       state, stateNext;
  logic [3:0]        cnt, cntNext;
  logic [ADDR_W-1:0] idxQ;
  logic [WORD_W-1:0] wdataQ;
  logic [BE_W-1:0]   byteEnQ;
  logic              writeQ, errQ;
  logic              accept, access, reqErr;
  logic [WORD_W-1:0] arrRData;

  assign reqErr = (ReqAddr[1:0] != 2'b00) || (ReqAddr[WORD_W-1:ADDR_W+2] != '0);
  assign accept = ReqValid && ReqReady;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idxQ    <= '0;
      wdataQ  <= '0;
      byteEnQ <= '0;
      writeQ  <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        idxQ    <= ReqAddr[ADDR_W+1:2];
        wdataQ  <= ReqWData;
        byteEnQ <= ReqByteEn;
        writeQ  <= ReqWrite;
        errQ    <= reqErr;
      end
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    ReqReady  = 1'b0;
    access    = 1'b0;
    unique case (state)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          stateNext = WAIT;
          cntNext   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          stateNext = RESP;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      RESP: begin
        // Retiring and accepting on the same edge keeps back-to-back spacing at LATENCY+1.
        ReqReady = RespReady;
        if (RespReady) begin
          if (ReqValid) begin
            stateNext = WAIT;
            cntNext   = CNT_LOAD;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  dmem_array #(.DEPTH(DEPTH)) uArray (
    .Clk   (Clk),
    .En    (access && !errQ),
    .We    (writeQ),
    .Addr  (idxQ),
    .ByteEn(byteEnQ),
    .WData (wdataQ),
    .RData (arrRData)
  );

  // RAM read register only updates on a load access, so gating it by state keeps data stable under stall.
  assign RespValid = (state == RESP);
  assign RespErr   = (state == RESP) && errQ;
  assign RespRData = ((state == RESP) && !writeQ && !errQ) ? arrRData : '0;
  assign Busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 2, 1, 15) driven with
// directed and random traffic, checked against a word-array reference model.
module tb_dmem_responder;
  import mips_pkg::*;

  localparam int NDUT  = 3;
  localparam int DEPTH = 256;

  function automatic int latOf(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  logic Clk = 1'b0;
  logic Rst_n = 1'b1;
  always #5 Clk = ~Clk;

  logic [NDUT-1:0] reqValid, reqReady, reqWrite, respValid, respReady, respErr, busy;
  logic [31:0] reqAddr [NDUT];
  logic [31:0] reqWData [NDUT];
  logic [31:0] respRData [NDUT];
  logic [3:0]  reqByteEn [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(latOf(g))) uDut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .ReqValid (reqValid[g]),
      .ReqReady (reqReady[g]),
      .ReqWrite (reqWrite[g]),
      .ReqAddr  (reqAddr[g]),
      .ReqWData (reqWData[g]),
      .ReqByteEn(reqByteEn[g]),
      .RespValid(respValid[g]),
      .RespReady(respReady[g]),
      .RespRData(respRData[g]),
      .RespErr  (respErr[g]),
      .Busy     (busy[g])
    );
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acceptCyc;
  } expT;

  expT         sbq [NDUT][$];
  bit          latDone [NDUT];
  logic [31:0] model [NDUT][DEPTH];
  bit          stall [NDUT];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic failNow(input string nm, input int d);
    checks++;
    failures++;
    $display("FAIL %s dut%0d actual=timeout required=event t=%0t", nm, d, $time);
  endtask

  // Backpressure: random RespReady unless a stall is forced.
  initial begin
    respReady = '0;
    forever begin
      @(posedge Clk);
      #2;
      for (int d = 0; d < NDUT; d++)
        respReady[d] = stall[d] ? 1'b0 : ($urandom_range(0, 99) < 70);
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge Clk) begin
    if (Rst_n) begin
      for (int d = 0; d < NDUT; d++) begin
        if (respValid[d]) begin
          chk("busy_in_resp", d, 32'(busy[d]), 32'd1);
          chk("req_ready_in_resp", d, 32'(reqReady[d]), 32'(respReady[d]));
          if (sbq[d].size() == 0) begin
            failNow("spurious_resp", d);
          end else begin
            if (!latDone[d]) begin
              chk("latency", d, 32'(cyc - sbq[d][0].acceptCyc), 32'(latOf(d)));
              latDone[d] = 1'b1;
            end
            chk("rdata", d, respRData[d], sbq[d][0].rdata);
            chk("err", d, 32'(respErr[d]), 32'(sbq[d][0].err));
            if (respReady[d]) begin
              sbq[d].delete(0);
              latDone[d] = 1'b0;
            end
          end
        end else if (!busy[d]) begin
          chk("rdata_idle", d, respRData[d], 32'd0);
          chk("err_idle", d, 32'(respErr[d]), 32'd0);
        end
      end
    end
  end

  task automatic doReq(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit push);
    int  waitc = 0;
    bit  acc = 1'b0;
    bit  err;
    logic [31:0] rd;
    int  idx;
    @(posedge Clk);
    #2;
    reqValid[d] = 1'b1;
    reqWrite[d] = wr;
    reqAddr[d] = a;
    reqWData[d] = wd;
    reqByteEn[d] = be;
    while (!acc && waitc <= 300) begin
      @(negedge Clk);
      #1;
      if (reqReady[d]) acc = 1'b1;
      @(posedge Clk);
      waitc++;
    end
    #1;
    if (!acc) begin
      failNow("accept_timeout", d);
    end else begin
      chk("busy_after_accept", d, 32'(busy[d]), 32'd1);
      chk("ready_after_accept", d, 32'(reqReady[d]), 32'd0);
      if (push) begin
        err = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
        rd = 32'd0;
        idx = int'(a >> 2) % DEPTH;
        if (!err) begin
          if (wr) begin
            for (int i = 0; i < 4; i++)
              if (be[i]) model[d][idx][8*i +: 8] = wd[8*i +: 8];
          end else begin
            rd = model[d][idx];
          end
        end
        sbq[d].push_back('{rdata: rd, err: err, acceptCyc: cyc});
      end
    end
    #1;
    reqValid[d] = 1'b0;
    reqWrite[d] = 1'($urandom);
    reqAddr[d] = $urandom;
    reqWData[d] = $urandom;
    reqByteEn[d] = 4'($urandom);
  endtask

  task automatic drain(input int d);
    int n = 0;
    while ((sbq[d].size() != 0 || busy[d]) && n < 600) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 600) failNow("drain_timeout", d);
  endtask

  task automatic initMem(input int d);
    for (int i = 0; i < 16; i++) doReq(d, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1);
    doReq(d, 1'b1, 32'h3FC, $urandom, 4'hF, 1'b1);
    drain(d);
  endtask

  task automatic randSeq(input int d, input int n);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 9))
        7:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        8:       a = $urandom | 32'h0000_0400;
        9:       a = ($urandom_range(0, 1) == 0) ? 32'h3FC : 32'h3FF;
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      doReq(d, 1'($urandom), a, $urandom, 4'($urandom), 1'b1);
    end
    drain(d);
  endtask

  task automatic stallTest();
    int n = 0;
    stall[0] = 1'b1;
    fork
      begin
        doReq(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        doReq(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
      end
      begin
        while (!respValid[0] && n < 50) begin
          @(negedge Clk);
          n++;
        end
        if (n >= 50) failNow("stall_resp_timeout", 0);
        repeat (3) @(posedge Clk);
        #1;
        stall[0] = 1'b0;
      end
    join
    drain(0);
  endtask

  initial begin
    reqValid = '0;
    reqWrite = '0;
    for (int d = 0; d < NDUT; d++) begin
      reqAddr[d] = '0;
      reqWData[d] = '0;
      reqByteEn[d] = '0;
      stall[d] = 1'b0;
      latDone[d] = 1'b0;
    end
    #3;
    Rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_req_ready", d, 32'(reqReady[d]), 32'd1);
      chk("rst_resp_valid", d, 32'(respValid[d]), 32'd0);
      chk("rst_rdata", d, respRData[d], 32'd0);
      chk("rst_err", d, 32'(respErr[d]), 32'd0);
      chk("rst_busy", d, 32'(busy[d]), 32'd0);
    end
    repeat (2) @(posedge Clk);
    #2;
    Rst_n = 1'b1;

    fork
      initMem(0);
      initMem(1);
      initMem(2);
    join

    // Store then load, partial store.
    doReq(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    doReq(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
    doReq(0, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1);
    doReq(0, 1'b1, 32'h20, 32'h0000AB00, 4'b0010, 1'b1);
    doReq(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    doReq(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b1);
    doReq(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    drain(0);
    chk("partial_store_model", 0, model[0][8], 32'h1234AB78);

    stallTest();

    // Errors: misaligned load, out-of-range store must not alias word 0.
    doReq(0, 1'b0, 32'h13, 32'h0, 4'hF, 1'b1);
    doReq(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b1);
    doReq(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1);
    drain(0);

    // Reset while a store is in WAIT: store must be discarded.
    doReq(0, 1'b1, 32'h30, 32'h11111111, 4'hF, 1'b1);
    drain(0);
    doReq(0, 1'b1, 32'h30, 32'h22222222, 4'hF, 1'b0);
    Rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 0, 32'(reqReady[0]), 32'd1);
    chk("midrst_resp_valid", 0, 32'(respValid[0]), 32'd0);
    chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
    chk("midrst_rdata", 0, respRData[0], 32'd0);
    chk("midrst_err", 0, 32'(respErr[0]), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    doReq(0, 1'b0, 32'h30, 32'h0, 4'hF, 1'b1);
    drain(0);
    chk("midrst_model_word", 0, model[0][12], 32'h11111111);

    fork
      randSeq(0, 60);
      randSeq(1, 60);
      randSeq(2, 15);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failNow("global_timeout", 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end

endmodule
